// File: rtl/esm_pkg.sv
// Shared types and default sizes for the ESM stream transactor.
package esm_pkg;

  localparam int ESM_ADC_WIDTH      = 16;
  localparam int ESM_AXI_DATA_WIDTH = 32;
  localparam int ESM_MAX_WORDS      = 16;

  // One ADC I/Q sample as carried through the sample strobe lane.
  typedef struct packed {
    logic signed [ESM_ADC_WIDTH-1:0] data_i;
    logic signed [ESM_ADC_WIDTH-1:0] data_q;
  } adc_transaction_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/esm_xactor_word_ram.sv
// Simple dual-port word RAM: synchronous write, synchronous read (read-old on collision).
module esm_xactor_word_ram
  import esm_pkg::*;
#(
  parameter int DEPTH = ESM_MAX_WORDS,
  parameter int WIDTH = ESM_AXI_DATA_WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; array contents are not reset.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; the output register alone is cleared so outputs start at 0.
  always_ff @(posedge Clk) begin
    if (!Resetn) rd_data <= '0;
    else         rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/esm_stream_xactor.sv
// ESM stream transactor: ADC strobe driver, AXIS packet master (TX) and AXIS packet slave (RX).
module esm_stream_xactor
  import esm_pkg::*;
#(
  parameter int ADC_WIDTH      = ESM_ADC_WIDTH,
  parameter int AXI_DATA_WIDTH = ESM_AXI_DATA_WIDTH,
  parameter int MAX_WORDS      = ESM_MAX_WORDS,
  localparam int AW            = $clog2(MAX_WORDS),
  localparam int PW            = AW + 1
) (
  input  logic                        Clk,
  input  logic                        Resetn,
  input  logic                        Adc_req_valid,
  input  logic signed [ADC_WIDTH-1:0] Adc_req_i,
  input  logic signed [ADC_WIDTH-1:0] Adc_req_q,
  output logic                        Adc_valid,
  output logic signed [ADC_WIDTH-1:0] Adc_data_i,
  output logic signed [ADC_WIDTH-1:0] Adc_data_q,
  input  logic                        Tx_wr_en,
  input  logic [AXI_DATA_WIDTH-1:0]   Tx_wr_data,
  input  logic                        Tx_start,
  output logic                        Tx_busy,
  output logic                        Tx_done,
  output logic                        M_axis_valid,
  output logic [AXI_DATA_WIDTH-1:0]   M_axis_data,
  output logic                        M_axis_last,
  input  logic                        M_axis_ready,
  input  logic                        S_axis_valid,
  input  logic [AXI_DATA_WIDTH-1:0]   S_axis_data,
  input  logic                        S_axis_last,
  output logic                        S_axis_ready,
  input  logic                        Rx_ready_en,
  input  logic [AW-1:0]               Rx_rd_addr,
  output logic [AXI_DATA_WIDTH-1:0]   Rx_rd_data,
  output logic                        Rx_done,
  output logic [PW-1:0]               Rx_len,
  output logic                        Rx_overflow
);

  localparam logic [PW-1:0] FULL = PW'(MAX_WORDS);

  // Packet length after one more beat, clamped to the buffer depth.
  function automatic logic [PW-1:0] sat_len(input logic [PW-1:0] cnt);
    if (cnt == FULL) return cnt;
    return cnt + 1'b1;
  endfunction

  // ---------------- ADC lane ----------------
  adc_transaction_t adc_p1;
  logic             vld_p1;

  // One-cycle sample register; data is forced to zero whenever no sample is requested.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      vld_p1 <= 1'b0;
      adc_p1 <= '0;
    end else begin
      vld_p1 <= Adc_req_valid;
      if (Adc_req_valid) begin
        adc_p1.data_i <= Adc_req_i;
        adc_p1.data_q <= Adc_req_q;
      end else begin
        adc_p1 <= '0;
      end
    end
  end

  assign Adc_valid  = vld_p1;
  assign Adc_data_i = adc_p1.data_i;
  assign Adc_data_q = adc_p1.data_q;

  // ---------------- TX lane ----------------
  tx_state_e                 tx_state, tx_state_nxt;
  logic [PW-1:0]             wr_ptr, tx_idx, tx_idx_nxt;
  logic                      tx_done_r, tx_last_beat, tx_wr_accept;
  logic                      m_valid, m_last;
  logic [AXI_DATA_WIDTH-1:0] tx_rd_data;

  assign tx_wr_accept = Tx_wr_en && (tx_state == TX_IDLE) && (wr_ptr != FULL);

  // TX state register.
  always_ff @(posedge Clk) begin
    if (!Resetn) tx_state <= TX_IDLE;
    else         tx_state <= tx_state_nxt;
  end

  // Next state, beat index and AXIS master outputs; the RAM reads at the next index so data lines up.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_idx_nxt   = tx_idx;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    tx_last_beat = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_idx_nxt = '0;
        if (Tx_start && (wr_ptr != '0)) tx_state_nxt = TX_SEND;
      end
      TX_SEND: begin
        m_valid = 1'b1;
        m_last  = (tx_idx == wr_ptr - 1'b1);
        if (M_axis_ready) begin
          if (m_last) begin
            tx_last_beat = 1'b1;
            tx_state_nxt = TX_IDLE;
            tx_idx_nxt   = '0;
          end else begin
            tx_idx_nxt = tx_idx + 1'b1;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Write pointer, beat index and done pulse; completing a packet empties the buffer.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      wr_ptr    <= '0;
      tx_idx    <= '0;
      tx_done_r <= 1'b0;
    end else begin
      tx_idx    <= tx_idx_nxt;
      tx_done_r <= tx_last_beat;
      if (tx_last_beat)      wr_ptr <= '0;
      else if (tx_wr_accept) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  esm_xactor_word_ram #(.DEPTH(MAX_WORDS), .WIDTH(AXI_DATA_WIDTH)) u_tx_ram (
    .Clk     (Clk),
    .Resetn  (Resetn),
    .wr_en   (tx_wr_accept),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (Tx_wr_data),
    .rd_addr (tx_idx_nxt[AW-1:0]),
    .rd_data (tx_rd_data)
  );

  assign Tx_busy      = (tx_state == TX_SEND);
  assign Tx_done      = tx_done_r;
  assign M_axis_valid = m_valid;
  assign M_axis_last  = m_last;
  assign M_axis_data  = m_valid ? tx_rd_data : '0;

  // ---------------- RX lane ----------------
  logic [PW-1:0] rx_cnt, rx_len_r;
  logic          rx_ovf_flag, rx_done_r, rx_ovf_r;
  logic          rx_accept, rx_full, rx_wr;

  assign S_axis_ready = Rx_ready_en;
  assign rx_accept    = S_axis_valid && Rx_ready_en;
  assign rx_full      = (rx_cnt == FULL);
  assign rx_wr        = rx_accept && !rx_full;

  // Beat counter, overflow tracking and per-packet completion report.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      rx_cnt      <= '0;
      rx_ovf_flag <= 1'b0;
      rx_done_r   <= 1'b0;
      rx_len_r    <= '0;
      rx_ovf_r    <= 1'b0;
    end else begin
      rx_done_r <= rx_accept && S_axis_last;
      if (rx_accept) begin
        if (S_axis_last) begin
          rx_len_r    <= sat_len(rx_cnt);
          rx_ovf_r    <= rx_ovf_flag | rx_full;
          rx_cnt      <= '0;
          rx_ovf_flag <= 1'b0;
        end else if (!rx_full) begin
          rx_cnt <= rx_cnt + 1'b1;
        end else begin
          rx_ovf_flag <= 1'b1;
        end
      end
    end
  end

  esm_xactor_word_ram #(.DEPTH(MAX_WORDS), .WIDTH(AXI_DATA_WIDTH)) u_rx_ram (
    .Clk     (Clk),
    .Resetn  (Resetn),
    .wr_en   (rx_wr),
    .wr_addr (rx_cnt[AW-1:0]),
    .wr_data (S_axis_data),
    .rd_addr (Rx_rd_addr),
    .rd_data (Rx_rd_data)
  );

  assign Rx_done     = rx_done_r;
  assign Rx_len      = rx_len_r;
  assign Rx_overflow = rx_ovf_r;

endmodule

// File: tb/tb_esm_stream_xactor.sv
// Directed bench for esm_stream_xactor: ADC strobe, TX packet master, RX packet slave, resets.
module tb_esm_stream_xactor;

  localparam int ADC_W = 16;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int PW    = 5;

  logic                    Clk = 1'b0;
  logic                    Resetn;
  logic                    Adc_req_valid;
  logic signed [ADC_W-1:0] Adc_req_i, Adc_req_q;
  logic                    Adc_valid;
  logic signed [ADC_W-1:0] Adc_data_i, Adc_data_q;
  logic                    Tx_wr_en;
  logic [DW-1:0]           Tx_wr_data;
  logic                    Tx_start, Tx_busy, Tx_done;
  logic                    M_axis_valid, M_axis_last, M_axis_ready;
  logic [DW-1:0]           M_axis_data;
  logic                    S_axis_valid, S_axis_last, S_axis_ready;
  logic [DW-1:0]           S_axis_data;
  logic                    Rx_ready_en;
  logic [AW-1:0]           Rx_rd_addr;
  logic [DW-1:0]           Rx_rd_data;
  logic                    Rx_done, Rx_overflow;
  logic [PW-1:0]           Rx_len;

  int test_cnt = 0;
  int fail_cnt = 0;

  logic [DW-1:0] txw [6];

  esm_stream_xactor dut (
    .Clk(Clk), .Resetn(Resetn),
    .Adc_req_valid(Adc_req_valid), .Adc_req_i(Adc_req_i), .Adc_req_q(Adc_req_q),
    .Adc_valid(Adc_valid), .Adc_data_i(Adc_data_i), .Adc_data_q(Adc_data_q),
    .Tx_wr_en(Tx_wr_en), .Tx_wr_data(Tx_wr_data), .Tx_start(Tx_start),
    .Tx_busy(Tx_busy), .Tx_done(Tx_done),
    .M_axis_valid(M_axis_valid), .M_axis_data(M_axis_data), .M_axis_last(M_axis_last),
    .M_axis_ready(M_axis_ready),
    .S_axis_valid(S_axis_valid), .S_axis_data(S_axis_data), .S_axis_last(S_axis_last),
    .S_axis_ready(S_axis_ready), .Rx_ready_en(Rx_ready_en),
    .Rx_rd_addr(Rx_rd_addr), .Rx_rd_data(Rx_rd_data),
    .Rx_done(Rx_done), .Rx_len(Rx_len), .Rx_overflow(Rx_overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired test_cnt=%0d", test_cnt);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rx_word(input int b);
    return 32'hC0DE0000 | 32'(b);
  endfunction

  task automatic tx_fill(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      Tx_wr_en   = 1'b1;
      Tx_wr_data = txw[first + i];
      tick();
    end
    Tx_wr_en = 1'b0;
  endtask

  initial begin
    int  beat, lasts, cyc, b, dones;
    logic rdy, stalled, held_last;
    logic [DW-1:0] held_data;

    txw[0] = 32'h45534D21; txw[1] = 32'h00000007; txw[2] = 32'h00000000;
    txw[3] = 32'hDEADBEEF; txw[4] = 32'h01000000; txw[5] = 32'hDEADBEEF;

    Resetn = 1'b0; Adc_req_valid = 1'b0; Adc_req_i = '0; Adc_req_q = '0;
    Tx_wr_en = 1'b0; Tx_wr_data = '0; Tx_start = 1'b0; M_axis_ready = 1'b0;
    S_axis_valid = 1'b0; S_axis_data = '0; S_axis_last = 1'b0;
    Rx_ready_en = 1'b0; Rx_rd_addr = '0;
    repeat (3) tick();

    // Reset state
    check1("rst_adc_valid", Adc_valid, 1'b0);
    check("rst_adc_i", {16'd0, Adc_data_i}, 32'h0);
    check1("rst_tx_busy", Tx_busy, 1'b0);
    check1("rst_tx_done", Tx_done, 1'b0);
    check1("rst_m_valid", M_axis_valid, 1'b0);
    check("rst_m_data", M_axis_data, 32'h0);
    check1("rst_m_last", M_axis_last, 1'b0);
    check1("rst_rx_done", Rx_done, 1'b0);
    check("rst_rx_len", 32'(Rx_len), 32'd0);
    check1("rst_rx_ovf", Rx_overflow, 1'b0);
    check("rst_rx_rd", Rx_rd_data, 32'h0);
    Resetn = 1'b1;
    tick();

    // ADC single request, then idle
    Adc_req_valid = 1'b1; Adc_req_i = 16'sd100; Adc_req_q = -16'sd5;
    tick();
    check1("adc_valid", Adc_valid, 1'b1);
    check("adc_i", {16'd0, Adc_data_i}, 32'h00000064);
    check("adc_q", {16'd0, Adc_data_q}, 32'h0000FFFB);
    Adc_req_valid = 1'b0; Adc_req_i = 16'sd7; Adc_req_q = 16'sd9;
    tick();
    check1("adc_idle_valid", Adc_valid, 1'b0);
    check("adc_idle_i", {16'd0, Adc_data_i}, 32'h0);
    check("adc_idle_q", {16'd0, Adc_data_q}, 32'h0);
    // ADC back-to-back
    Adc_req_valid = 1'b1; Adc_req_i = 16'sd1; Adc_req_q = 16'sd2;
    tick();
    check("adc_b2b0_i", {16'd0, Adc_data_i}, 32'h1);
    Adc_req_i = 16'sd3; Adc_req_q = -16'sd4;
    tick();
    check1("adc_b2b1_valid", Adc_valid, 1'b1);
    check("adc_b2b1_q", {16'd0, Adc_data_q}, 32'h0000FFFC);
    Adc_req_valid = 1'b0;
    tick();

    // TX full-rate packet
    tx_fill(6, 0);
    M_axis_ready = 1'b1; Tx_start = 1'b1;
    tick();
    Tx_start = 1'b0;
    check1("tx_busy", Tx_busy, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check1("tx_valid", M_axis_valid, 1'b1);
      check("tx_data", M_axis_data, txw[k]);
      check1("tx_last", M_axis_last, k == 5);
      check1("tx_done_early", Tx_done, 1'b0);
      tick();
    end
    check1("tx_done", Tx_done, 1'b1);
    check1("tx_idle_busy", Tx_busy, 1'b0);
    check1("tx_idle_valid", M_axis_valid, 1'b0);
    check("tx_idle_data", M_axis_data, 32'h0);
    tick();
    check1("tx_done_pulse", Tx_done, 1'b0);

    // Start with empty buffer is ignored
    Tx_start = 1'b1;
    tick();
    Tx_start = 1'b0;
    check1("tx_empty_start", Tx_busy, 1'b0);

    // TX with random backpressure
    M_axis_ready = 1'b0;
    tx_fill(6, 0);
    Tx_start = 1'b1;
    tick();
    Tx_start = 1'b0;
    beat = 0; lasts = 0; cyc = 0; stalled = 1'b0; held_data = '0; held_last = 1'b0;
    while (beat < 6 && cyc < 300) begin
      cyc++;
      check1("tx_bp_valid", M_axis_valid, 1'b1);
      if (stalled) begin
        check("tx_bp_hold_data", M_axis_data, held_data);
        check1("tx_bp_hold_last", M_axis_last, held_last);
      end
      check("tx_bp_data", M_axis_data, txw[beat]);
      check1("tx_bp_last", M_axis_last, beat == 5);
      rdy = ($urandom_range(0, 99) < 80);
      M_axis_ready = rdy;
      stalled = M_axis_valid && !rdy;
      held_data = M_axis_data; held_last = M_axis_last;
      if (M_axis_valid && rdy) begin
        if (M_axis_last) lasts++;
        beat++;
      end
      tick();
    end
    check("tx_bp_beats", 32'(beat), 32'd6);
    check("tx_bp_lasts", 32'(lasts), 32'd1);
    check1("tx_bp_done", Tx_done, 1'b1);
    M_axis_ready = 1'b0;
    tick();

    // Reset in the middle of a TX packet
    tx_fill(4, 0);
    M_axis_ready = 1'b1; Tx_start = 1'b1;
    tick();
    Tx_start = 1'b0;
    tick();
    tick();
    M_axis_ready = 1'b0; Resetn = 1'b0;
    tick();
    check1("txrst_valid", M_axis_valid, 1'b0);
    check1("txrst_busy", Tx_busy, 1'b0);
    check1("txrst_done", Tx_done, 1'b0);
    Resetn = 1'b1;
    tick();
    check1("txrst_done_after", Tx_done, 1'b0);
    tx_fill(1, 3);
    M_axis_ready = 1'b1; Tx_start = 1'b1;
    tick();
    Tx_start = 1'b0;
    check("txrst_single_data", M_axis_data, txw[3]);
    check1("txrst_single_last", M_axis_last, 1'b1);
    tick();
    check1("txrst_single_done", Tx_done, 1'b1);
    M_axis_ready = 1'b0;
    tick();

    // RX 13-beat packet with random backpressure
    b = 0; cyc = 0; dones = 0;
    while (b < 13 && cyc < 400) begin
      cyc++;
      S_axis_valid = 1'b1; S_axis_data = rx_word(b); S_axis_last = (b == 12);
      rdy = ($urandom_range(0, 99) < 70);
      Rx_ready_en = rdy;
      #1;
      check1("rx_ready_pass", S_axis_ready, rdy);
      tick();
      if (Rx_done) dones++;
      if (rdy) b++;
    end
    S_axis_valid = 1'b0; S_axis_last = 1'b0;
    repeat (2) begin
      tick();
      if (Rx_done) dones++;
    end
    check("rx_beats", 32'(b), 32'd13);
    check("rx_done_cnt", 32'(dones), 32'd1);
    check("rx_len13", 32'(Rx_len), 32'd13);
    check1("rx_ovf13", Rx_overflow, 1'b0);
    for (int a = 0; a < 13; a++) begin
      Rx_rd_addr = AW'(a);
      tick();
      check("rx_read", Rx_rd_data, rx_word(a));
    end

    // RX 20-beat overflow packet
    Rx_ready_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      S_axis_valid = 1'b1; S_axis_data = rx_word(k + 100); S_axis_last = (k == 19);
      tick();
    end
    S_axis_valid = 1'b0; S_axis_last = 1'b0;
    check1("rx_ovf_done", Rx_done, 1'b1);
    check("rx_ovf_len", 32'(Rx_len), 32'd16);
    check1("rx_ovf_flag", Rx_overflow, 1'b1);
    Rx_rd_addr = 4'd15;
    tick();
    check("rx_ovf_word15", Rx_rd_data, rx_word(115));
    check1("rx_ovf_pulse", Rx_done, 1'b0);

    // RX single-beat packet after overflow
    S_axis_valid = 1'b1; S_axis_data = rx_word(200); S_axis_last = 1'b1;
    tick();
    S_axis_valid = 1'b0; S_axis_last = 1'b0;
    check1("rx_one_done", Rx_done, 1'b1);
    check("rx_one_len", 32'(Rx_len), 32'd1);
    check1("rx_one_ovf", Rx_overflow, 1'b0);
    tick();
    check1("rx_one_pulse", Rx_done, 1'b0);
    check("rx_one_hold", 32'(Rx_len), 32'd1);

    // Reset in the middle of an RX packet
    for (int k = 0; k < 3; k++) begin
      S_axis_valid = 1'b1; S_axis_data = rx_word(300 + k); S_axis_last = 1'b0;
      tick();
    end
    S_axis_valid = 1'b0;
    Resetn = 1'b0;
    tick();
    check1("rxrst_done", Rx_done, 1'b0);
    check("rxrst_len", 32'(Rx_len), 32'd0);
    Resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      S_axis_valid = 1'b1; S_axis_data = rx_word(400 + k); S_axis_last = (k == 1);
      tick();
    end
    S_axis_valid = 1'b0; S_axis_last = 1'b0;
    check1("rxrst_pkt_done", Rx_done, 1'b1);
    check("rxrst_pkt_len", 32'(Rx_len), 32'd2);
    Rx_rd_addr = 4'd0;
    tick();
    check("rxrst_word0", Rx_rd_data, rx_word(400));

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
